// File: rtl/parking_capacity_tracker.sv
// parking_capacity_tracker: debounced spot occupancy, pending-entry tracking and
// entry-gate request/grant/deny handshake for a NUM_SPOTS parking lot.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   spot_raw            raw spot sensors, 1 = car present
//   entry_req           level request from a car waiting at the entry gate
//   entry_gnt           gate open, held until entry_req falls
//   entry_deny          lot full, held until entry_req falls
//   spot_occ            debounced occupancy vector
//   occ_cnt             registered popcount of spot_occ
//   pend_cnt            granted cars that have not parked yet
//   free_cnt            NUM_SPOTS - occ_cnt - pend_cnt, floored at 0
//   full, empty         free_cnt == 0 / nothing occupied or pending
// Optional (define CAPACITY_STATS_EN):
//   stats_clr           synchronous clear of the statistics (wins over updates)
//   peak_occ            highest occ_cnt since reset/clear
//   deny_cnt            saturating count of DENY entries
module parking_capacity_tracker #(
    parameter int NUM_SPOTS = 8,
    parameter int DEB_CYC   = 4,
    localparam int CNT_W    = $clog2(NUM_SPOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SPOTS-1:0] spot_raw,
    input  logic                 entry_req,
`ifdef CAPACITY_STATS_EN
    input  logic                 stats_clr,
    output logic [CNT_W-1:0]     peak_occ,
    output logic [15:0]          deny_cnt,
`endif
    output logic                 entry_gnt,
    output logic                 entry_deny,
    output logic [NUM_SPOTS-1:0] spot_occ,
    output logic [CNT_W-1:0]     occ_cnt,
    output logic [CNT_W-1:0]     pend_cnt,
    output logic [CNT_W-1:0]     free_cnt,
    output logic                 full,
    output logic                 empty
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DENY  = 2'd2;

    localparam logic [7:0]     DEB_LAST = 8'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(NUM_SPOTS);
    localparam logic [CNT_W:0]   N_X    = (CNT_W + 1)'(NUM_SPOTS);

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_SPOTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic [NUM_SPOTS-1:0] r_stable;
    logic [NUM_SPOTS-1:0] r_counted;
    logic [7:0]           r_deb_cnt [NUM_SPOTS];
    logic [CNT_W-1:0]     r_occ_cnt;
    logic [CNT_W-1:0]     r_pend_cnt;
    logic [1:0]           r_state;
    logic                 r_gnt;
    logic                 r_deny;

    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_park;
    logic [CNT_W:0]   w_used;
    logic [CNT_W-1:0] w_free;
    logic [CNT_W:0]   w_pend_up;
    logic [CNT_W:0]   w_pend_dn;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             w_idle_req;
    logic             w_grant;
    logic             w_to_deny;
    logic [1:0]       w_state_nxt;

    // Per-spot debounce: stable flips only after DEB_CYC consecutive
    // samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int i = 0; i < NUM_SPOTS; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPOTS; i++) begin
                if (spot_raw[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_stable[i]  <= ~r_stable[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    // r_counted is the vector occ_cnt currently reflects; parks are
    // counted on the same edge occ_cnt picks them up, so free_cnt
    // never sees a car both pending and parked.
    assign w_occ_nxt = popcnt(r_stable);
    assign w_park    = popcnt(r_stable & ~r_counted);

    assign w_used = {1'b0, r_occ_cnt} + {1'b0, r_pend_cnt};
    assign w_free = (w_used >= N_X) ? '0 : CNT_W'(N_X - w_used);

    assign w_idle_req = (r_state == ST_IDLE) && entry_req;
    assign w_grant    = w_idle_req && (w_free != '0);
    assign w_to_deny  = w_idle_req && (w_free == '0);

    assign w_pend_up  = {1'b0, r_pend_cnt} + {{CNT_W{1'b0}}, w_grant};
    assign w_pend_dn  = (w_pend_up > {1'b0, w_park})
                      ? w_pend_up - {1'b0, w_park} : '0;
    assign w_pend_nxt = (w_pend_dn > N_X) ? N_CNT : w_pend_dn[CNT_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_GRANT;
                end else if (w_to_deny) begin
                    w_state_nxt = ST_DENY;
                end
            end
            ST_GRANT, ST_DENY: begin
                if (!entry_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counted  <= '0;
            r_occ_cnt  <= '0;
            r_pend_cnt <= '0;
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_deny     <= 1'b0;
        end else begin
            r_counted  <= r_stable;
            r_occ_cnt  <= w_occ_nxt;
            r_pend_cnt <= w_pend_nxt;
            r_state    <= w_state_nxt;
            r_gnt      <= (w_state_nxt == ST_GRANT);
            r_deny     <= (w_state_nxt == ST_DENY);
        end
    end

`ifdef CAPACITY_STATS_EN
    logic [CNT_W-1:0] r_peak;
    logic [15:0]      r_deny_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak     <= '0;
            r_deny_cnt <= '0;
        end else if (stats_clr) begin
            r_peak     <= '0;
            r_deny_cnt <= '0;
        end else begin
            if (w_occ_nxt > r_peak) begin
                r_peak <= w_occ_nxt;
            end
            if (w_to_deny && (r_deny_cnt != 16'hFFFF)) begin
                r_deny_cnt <= r_deny_cnt + 16'd1;
            end
        end
    end

    assign peak_occ = r_peak;
    assign deny_cnt = r_deny_cnt;
`endif

    assign spot_occ   = r_stable;
    assign occ_cnt    = r_occ_cnt;
    assign pend_cnt   = r_pend_cnt;
    assign free_cnt   = w_free;
    assign full       = (w_free == '0);
    assign empty      = (r_occ_cnt == '0) && (r_pend_cnt == '0);
    assign entry_gnt  = r_gnt;
    assign entry_deny = r_deny;

endmodule

// File: tb/tb_parking_capacity_tracker.sv
// tb_parking_capacity_tracker: directed stimulus, behavioural model compared
// every cycle, plus hand-computed literal checks.
module tb_parking_capacity_tracker;

    localparam int N = 8;
    localparam int D = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  spot_raw = '0;
    logic          entry_req = 1'b0;
    logic          entry_gnt;
    logic          entry_deny;
    logic [N-1:0]  spot_occ;
    logic [CW-1:0] occ_cnt;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] free_cnt;
    logic          full;
    logic          empty;
`ifdef CAPACITY_STATS_EN
    logic          stats_clr = 1'b0;
    logic [CW-1:0] peak_occ;
    logic [15:0]   deny_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    parking_capacity_tracker #(.NUM_SPOTS(N), .DEB_CYC(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spot_raw  (spot_raw),
        .entry_req (entry_req),
`ifdef CAPACITY_STATS_EN
        .stats_clr (stats_clr),
        .peak_occ  (peak_occ),
        .deny_cnt  (deny_cnt),
`endif
        .entry_gnt (entry_gnt),
        .entry_deny(entry_deny),
        .spot_occ  (spot_occ),
        .occ_cnt   (occ_cnt),
        .pend_cnt  (pend_cnt),
        .free_cnt  (free_cnt),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: raw sample history, occupancy seen one cycle
    // late, pending cars as a clamped integer, gate as two flags.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_stab = '0;
    logic [N-1:0] m_prev = '0;
    int  m_occ = 0;
    int  m_pend = 0;
    bit  m_gnt = 0;
    bit  m_deny = 0;
    int  m_peak = 0;
    int  m_dcnt = 0;
    int  m_parks;
    int  m_fnow;
    bit  m_g;
    bit  m_d;
    bit  m_all;

    function automatic int m_free();
        int f;
        f = N - m_occ - m_pend;
        return (f < 0) ? 0 : f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_stab = '0; m_prev = '0; m_occ = 0; m_pend = 0;
            m_gnt = 0; m_deny = 0; m_peak = 0; m_dcnt = 0;
        end else begin
            m_fnow = m_free();
            m_g = 0;
            m_d = 0;
            if (m_gnt || m_deny) begin
                if (!entry_req) begin
                    m_gnt = 0;
                    m_deny = 0;
                end
            end else if (entry_req) begin
                if (m_fnow > 0) begin
                    m_gnt = 1; m_g = 1;
                end else begin
                    m_deny = 1; m_d = 1;
                end
            end
            m_parks = $countones(m_stab & ~m_prev);
            m_occ = $countones(m_stab);
            m_prev = m_stab;
            m_pend = m_pend + int'(m_g) - m_parks;
            if (m_pend < 0) m_pend = 0;
            if (m_pend > N) m_pend = N;
            hist.push_back(spot_raw);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                for (int s = 0; s < N; s++) begin
                    m_all = 1;
                    foreach (hist[k]) if (hist[k][s] == m_stab[s]) m_all = 0;
                    if (m_all) m_stab[s] = ~m_stab[s];
                end
            end
`ifdef CAPACITY_STATS_EN
            if (stats_clr) begin
                m_peak = 0;
                m_dcnt = 0;
            end else begin
                if (m_occ > m_peak) m_peak = m_occ;
                if (m_d && m_dcnt < 65535) m_dcnt++;
            end
`endif
        end
    end

    always @(negedge clk) begin
        chk("spot_occ", spot_occ, m_stab);
        chk("occ_cnt", occ_cnt, m_occ);
        chk("pend_cnt", pend_cnt, m_pend);
        chk("free_cnt", free_cnt, m_free());
        chk("full", full, m_free() == 0);
        chk("empty", empty, (m_occ == 0) && (m_pend == 0));
        chk("entry_gnt", entry_gnt, m_gnt);
        chk("entry_deny", entry_deny, m_deny);
        chk("gnt_deny_excl", entry_gnt & entry_deny, 0);
`ifdef CAPACITY_STATS_EN
        chk("peak_occ", peak_occ, m_peak);
        chk("deny_cnt", deny_cnt, m_dcnt);
`endif
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        tick(3);
        chk("rst_occ", occ_cnt, 0);
        chk("rst_free", free_cnt, 8);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_gnt", entry_gnt, 0);
        rst_n = 1'b1;
        tick(2);

        spot_raw = 8'h08;
        tick(3);
        spot_raw = 8'h00;
        tick(6);
        chk("glitch_occ", spot_occ, 8'h00);
        spot_raw = 8'h08;
        tick(3);
        chk("deb_early", spot_occ, 8'h00);
        tick(1);
        chk("deb_occ", spot_occ, 8'h08);
        chk("deb_cnt_lag", occ_cnt, 0);
        tick(1);
        chk("deb_cnt", occ_cnt, 1);
        chk("deb_pend", pend_cnt, 0);

        spot_raw = 8'h7F;
        tick(5);
        chk("seven_occ", occ_cnt, 7);
        chk("seven_free", free_cnt, 1);
        entry_req = 1'b1;
        tick(1);
        chk("g1_gnt", entry_gnt, 1);
        chk("g1_pend", pend_cnt, 1);
        chk("g1_full", full, 1);
        entry_req = 1'b0;
        tick(1);
        chk("g1_drop", entry_gnt, 0);
        entry_req = 1'b1;
        tick(1);
        chk("d1_deny", entry_deny, 1);
        tick(3);
        chk("d1_hold", entry_deny, 1);
        chk("d1_nognt", entry_gnt, 0);
        entry_req = 1'b0;
        tick(1);
        chk("d1_drop", entry_deny, 0);

        spot_raw = 8'h03;
        tick(5);
        chk("exit_occ", occ_cnt, 2);
        chk("exit_pend", pend_cnt, 1);
        chk("exit_free", free_cnt, 5);
        spot_raw = 8'h83;
        tick(4);
        entry_req = 1'b1;
        tick(1);
        chk("cancel_gnt", entry_gnt, 1);
        chk("cancel_pend", pend_cnt, 1);
        chk("cancel_occ", occ_cnt, 3);
        chk("cancel_free", free_cnt, 4);
        entry_req = 1'b0;
        tick(1);
        entry_req = 1'b1;
        tick(1);
        chk("g3_pend", pend_cnt, 2);
        entry_req = 1'b0;
        tick(1);
        spot_raw = 8'h00;
        tick(5);
        chk("clr_occ", occ_cnt, 0);
        chk("clr_pend", pend_cnt, 2);
        chk("clr_free", free_cnt, 6);
        spot_raw = 8'hFF;
        tick(4);
        chk("all_occ", spot_occ, 8'hFF);
        chk("all_pend_pre", pend_cnt, 2);
        tick(1);
        chk("all_pend", pend_cnt, 0);
        chk("all_cnt", occ_cnt, 8);
        chk("all_free", free_cnt, 0);
        chk("all_full", full, 1);

        spot_raw = 8'h00;
        tick(5);
        entry_req = 1'b1;
        tick(1);
        chk("r_gnt_pre", entry_gnt, 1);
        chk("r_pend_pre", pend_cnt, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("r_gnt_drop", entry_gnt, 0);
        chk("r_pend_drop", pend_cnt, 0);
        chk("r_empty", empty, 1);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("r_regnt", entry_gnt, 1);
        chk("r_repend", pend_cnt, 1);
        entry_req = 1'b0;
        tick(1);

`ifdef CAPACITY_STATS_EN
        spot_raw = 8'hFF;
        tick(5);
        repeat (3) begin
            entry_req = 1'b1;
            tick(1);
            entry_req = 1'b0;
            tick(1);
        end
        chk("st_deny3", deny_cnt, 3);
        spot_raw = 8'h00;
        tick(5);
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        chk("st_clr_peak", peak_occ, 0);
        chk("st_clr_deny", deny_cnt, 0);
        spot_raw = 8'h3F;
        tick(5);
        chk("st_peak6", peak_occ, 6);
        spot_raw = 8'h03;
        tick(5);
        chk("st_occ2", occ_cnt, 2);
        chk("st_peak_hold", peak_occ, 6);
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        chk("st_clr2_peak", peak_occ, 0);
        chk("st_clr2_deny", deny_cnt, 0);
`endif
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
